// File: rtl/ps2_rx_buffered_pkg.sv
// Shared types and constants for the buffered PS/2 receive path.
package ps2_rx_buffered_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_rx_state_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    function automatic logic odd_parity_bit(input byte_t b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_rx_buffered_if.sv
// Ready/valid byte stream from the PS/2 receiver to its consumer.
interface ps2_rx_buffered_if;
    import ps2_rx_buffered_pkg::*;

    byte_t data_o;
    logic  valid_o;
    logic  ready_i;

    modport master (output data_o, output valid_o, input ready_i);
    modport slave  (input data_o, input valid_o, output ready_i);

endinterface

// File: rtl/ps2_rx_buffered_fifo_sync.sv
// fifo_sync: single-clock first-word-fall-through FIFO; DEPTH must be a power of two.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign data_o    = r_mem[r_rptr];
    assign level_o   = r_count;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= data_i;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_buffered.sv
// Buffered PS/2 device-to-host receiver: sync, clock filter, frame FSM, FIFO.
// Optional stalled-frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_buffered
    import ps2_rx_buffered_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        ps2_clk_async_i,
    input  logic                        ps2_data_async_i,
    ps2_rx_buffered_if.master           rx_bus,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic                        err_parity_o,
    output logic                        err_frame_o,
    output logic                        overflow_o
);

    localparam int FCW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   w_clk_s;
    logic                   w_dat_s;
    logic                   r_filt;
    logic [FCW-1:0]         r_filt_cnt;
    logic                   w_filt_flip;
    logic                   r_fall;

    ps2_rx_state_t r_state, w_state_next;
    byte_t         r_shift;
    logic [2:0]    r_bitcnt;
    logic          r_parity;
    logic          w_start, w_shift, w_cap_par;
    logic          w_push, w_perr, w_ferr;
    logic          w_timeout;
    logic          r_err_parity, r_err_frame, r_overflow;

    byte_t         w_head;
    logic          w_full, w_empty, w_pop;

    // Reset loads idle-high so the pins never look like a falling edge afterwards.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk_async_i};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data_async_i};
        end
    end

    assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s     = r_dat_sync[SYNC_STAGES-1];
    assign w_filt_flip = (w_clk_s != r_filt) && (r_filt_cnt == FCW'(FILTER_LEN - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_filt     <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_fall <= w_filt_flip && r_filt;
            if (w_clk_s == r_filt) begin
                r_filt_cnt <= '0;
            end else if (w_filt_flip) begin
                r_filt     <= w_clk_s;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WCW-1:0] r_wd_cnt;

    // Hits TIMEOUT_CYCLES-1 in the TIMEOUT_CYCLES-th cycle after the last fall.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wd_cnt <= '0;
        end else if (r_fall) begin
            r_wd_cnt <= '0;
        end else if (r_state != ST_IDLE && r_wd_cnt != WCW'(TIMEOUT_CYCLES)) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state != ST_IDLE) && !r_fall &&
                       (r_wd_cnt == WCW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_cap_par    = 1'b0;
        w_push       = 1'b0;
        w_perr       = 1'b0;
        w_ferr       = 1'b0;
        if (w_timeout) begin
            w_state_next = ST_IDLE;
            w_ferr       = 1'b1;
        end else if (r_fall) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_dat_s) begin
                        w_state_next = ST_DATA;
                        w_start      = 1'b1;
                    end
                end
                ST_DATA: begin
                    w_shift = 1'b1;
                    if (r_bitcnt == 3'd7) w_state_next = ST_PARITY;
                end
                ST_PARITY: begin
                    w_cap_par    = 1'b1;
                    w_state_next = ST_STOP;
                end
                ST_STOP: begin
                    w_state_next = ST_IDLE;
                    if (!w_dat_s)                                w_ferr = 1'b1;
                    else if (r_parity != odd_parity_bit(r_shift)) w_perr = 1'b1;
                    else                                         w_push = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_parity     <= 1'b0;
            r_err_parity <= 1'b0;
            r_err_frame  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_start) r_bitcnt <= '0;
            if (w_shift) begin
                r_shift  <= {w_dat_s, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 1'b1;
            end
            if (w_cap_par) r_parity <= w_dat_s;
            r_err_parity <= w_perr;
            r_err_frame  <= w_ferr;
            r_overflow   <= w_push && w_full && !w_pop;
        end
    end

    assign w_pop = rx_bus.ready_i && !w_empty;

    fifo_sync #(
        .WIDTH ($bits(byte_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_push),
        .data_i  (r_shift),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (level_o)
    );

    assign rx_bus.data_o  = w_head;
    assign rx_bus.valid_o = !w_empty;
    assign err_parity_o   = r_err_parity;
    assign err_frame_o    = r_err_frame;
    assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Bench for ps2_rx_buffered: directed frames plus random traffic against a queue model.
module tb_ps2_rx_buffered;
    import ps2_rx_buffered_pkg::*;

    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
    localparam int FILT  = 8;
    localparam int TMO   = 600;
    localparam int HALF  = 25;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_i   = 1'b0;
    logic          reset_i = 1'b1;
    logic          ps2_clk = 1'b1;
    logic          ps2_dat = 1'b1;
    logic [LW-1:0] level;
    logic          perr, ferr, ovf;

    ps2_rx_buffered_if rx_if();

    ps2_rx_buffered #(
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (SYNC),
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .ps2_clk_async_i  (ps2_clk),
        .ps2_data_async_i (ps2_dat),
        .rx_bus           (rx_if),
        .level_o          (level),
        .err_parity_o     (perr),
        .err_frame_o      (ferr),
        .overflow_o       (ovf)
    );

    always #10 clk_i = ~clk_i;

    int    n_tests = 0, n_fail = 0;
    int    cyc = 0;
    int    ready_mode = 0;  // 0 hold low, 1 hold high, 2 random
    int    n_perr = 0, n_ferr = 0, n_ovf = 0;
    int    exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
    int    last_fall_cyc = 0, last_ferr_cyc = 0;
    byte_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial begin
        rx_if.ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            case (ready_mode)
                1:       rx_if.ready_i = 1'b1;
                2:       rx_if.ready_i = 1'($urandom_range(0, 1));
                default: rx_if.ready_i = 1'b0;
            endcase
        end
    end

    // Pops and pulses are observed mid-cycle, before the edge that acts on them.
    initial forever begin
        @(negedge clk_i);
        if (!reset_i) begin
            if (rx_if.valid_o && rx_if.ready_i) begin
                if (q.size() == 0) chk("pop_empty", 32'(rx_if.valid_o), 32'd0);
                else               chk("pop_data", 32'(rx_if.data_o), 32'(q.pop_front()));
            end
            if (perr) n_perr++;
            if (ovf)  n_ovf++;
            if (ferr) begin
                n_ferr++;
                last_ferr_cyc = cyc;
            end
        end
    end

    // Expected outcome of a completed frame, straight from the frame rules.
    task automatic model_frame(input byte_t d, input logic parbit, input logic stop);
        if (!stop)                exp_ferr++;
        else if (parbit != ~^d)   exp_perr++;
        else if (q.size() >= DEPTH) exp_ovf++;
        else                      q.push_back(d);
    endtask

    task automatic send_frame(input byte_t d, input bit bad_par, input bit stop,
                              input bit glitch, input int nbits);
        logic [PS2_FRAME_BITS-1:0] fr;
        fr = {stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            if (glitch && i == 3) begin
                wait_cyc(8);
                ps2_clk = 1'b0;
                wait_cyc(3);
                ps2_clk = 1'b1;
                wait_cyc(HALF - 11);
            end else begin
                wait_cyc(HALF);
            end
            if (i == PS2_FRAME_BITS - 1) model_frame(d, fr[9], stop);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic post_frame();
        wait_cyc(40);
        chk("perr_cnt", 32'(n_perr), 32'(exp_perr));
        chk("ferr_cnt", 32'(n_ferr), 32'(exp_ferr));
        chk("ovf_cnt", 32'(n_ovf), 32'(exp_ovf));
        if (ready_mode != 2) begin
            chk("level", 32'(level), 32'(q.size()));
            chk("valid", 32'(rx_if.valid_o), 32'(q.size() != 0));
        end
    endtask

    task automatic frame(input byte_t d, input bit bad_par, input bit stop);
        send_frame(d, bad_par, stop, 1'b0, PS2_FRAME_BITS);
        post_frame();
    endtask

    initial begin
        reset_i = 1'b1;
        wait_cyc(3);
        @(negedge clk_i);
        chk("rst_valid", 32'(rx_if.valid_o), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_data", 32'(rx_if.data_o), 32'd0);
        chk("rst_perr", 32'(perr), 32'd0);
        chk("rst_ferr", 32'(ferr), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        wait_cyc(1);
        reset_i = 1'b0;
        wait_cyc(20);

        // good frame, parity error, framing error then recovery
        ready_mode = 1;
        frame(8'h76, 1'b0, 1'b1);
        frame(8'h76, 1'b1, 1'b1);
        frame(8'h1C, 1'b0, 1'b0);
        frame(8'h1C, 1'b0, 1'b1);

        // fill past depth with the consumer stalled, then drain
        ready_mode = 0;
        for (int i = 1; i <= 9; i++) frame(byte_t'(i), 1'b0, 1'b1);
        ready_mode = 1;
        wait_cyc(30);
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_valid", 32'(rx_if.valid_o), 32'd0);
        chk("drain_model", 32'(q.size()), 32'(level));

`ifdef PS2_RX_TIMEOUT_EN
        begin
            int waited;
            send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 5);
            exp_ferr++;
            waited = 0;
            while (n_ferr < exp_ferr && waited < TMO + 200) begin
                wait_cyc(1);
                waited++;
            end
            chk("wd_fired", 32'(n_ferr), 32'(exp_ferr));
            chk("wd_delay", 32'(last_ferr_cyc - last_fall_cyc), 32'(TMO + SYNC + FILT + 1));
            post_frame();
            frame(8'hF0, 1'b0, 1'b1);
        end
`endif

        // reset mid-frame with bytes buffered, then a glitched good frame
        ready_mode = 0;
        frame(8'h33, 1'b0, 1'b1);
        frame(8'h44, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b0, 5);
        reset_i = 1'b1;
        q.delete();
        wait_cyc(4);
        reset_i = 1'b0;
        wait_cyc(2);
        chk("rst_mid_level", 32'(level), 32'd0);
        chk("rst_mid_valid", 32'(rx_if.valid_o), 32'd0);
        ready_mode = 1;
        send_frame(8'hF0, 1'b0, 1'b1, 1'b1, PS2_FRAME_BITS);
        post_frame();

        // random traffic with a random consumer
        ready_mode = 2;
        for (int i = 0; i < 16; i++) begin
            frame(byte_t'($urandom_range(0, 255)),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) != 0));
        end
        ready_mode = 1;
        wait_cyc(30);
        chk("final_level", 32'(level), 32'(q.size()));
        chk("final_valid", 32'(rx_if.valid_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
